axis_lane_packer: RTL and testbench
===================================

# axis_lane_packer

Parametrised successor to the Sobel debug output stage. Takes an AXI4-Stream video beat carrying NUM_CH parallel pixel channels (raw, Gx, Gy, magnitude, …) and packs a runtime-selected channel into each of LANES output lanes. The lane map is updated only at frame start. Full tready/tvalid backpressure is supported through a skid buffer. Per-line length checking and a frame counter are included for debug. The block sits between the filter core and the VDMA/video-out stream.

## Interface
- DATA_WIDTH, 10, bits per input channel
- NUM_CH, 4, input channels per beat
- LANES, 4, output lanes per beat
- LANE_WIDTH, 8, bits per output lane
- IMG_WIDTH, 640, expected beats per line
- SEL_W, $clog2(NUM_CH+1), lane-select field width
- pixel_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- lane_sel  in  LANES*SEL_W  lane i source = lane_sel[i*SEL_W +: SEL_W]; a value ≥ NUM_CH outputs zero
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  channel c = [c*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid / s_axis_tuser / s_axis_tlast  in  1  AXIS input sideband
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  LANES*LANE_WIDTH  lane i = [i*LANE_WIDTH +: LANE_WIDTH]
- m_axis_tvalid / m_axis_tuser / m_axis_tlast  out  1  AXIS output sideband
- m_axis_tready  in  1  downstream ready
- err_clear  in  1  clears line_err
- line_err  out  1  sticky line-length error
- frame_cnt  out  16  accepted SOF beats, wraps at 2^16

## Operation
- **Accept rule:** an input beat is accepted when s_axis_tvalid && s_axis_tready.
- **FSM states:** WAIT_SOF and ACTIVE. Reset enters WAIT_SOF.
  - In WAIT_SOF, accepted beats with tuser=0 are discarded (not forwarded, not counted).
  - An accepted beat with tuser=1 latches lane_sel into the active map, is forwarded, and moves the FSM to ACTIVE.
- **ACTIVE:** every accepted beat is forwarded. An accepted tuser=1 beat re-latches lane_sel, and that beat already uses the new map. lane_sel changes between SOFs have no effect.
- **Lane packing:**
  - If LANE_WIDTH ≤ DATA_WIDTH, lane = the MSBs of the channel (channel[DATA_WIDTH-1 -: LANE_WIDTH]).
  - Otherwise lane = {channel, zeros}, i.e. MSB-aligned with zero-padded LSBs.
  - A select value ≥ NUM_CH gives an all-zero lane.
- **tuser/tlast** travel unchanged alongside their beat.
- **Line check:** pix_cnt counts accepted beats in ACTIVE.
  - tlast with pix_cnt ≠ IMG_WIDTH-1 sets line_err; pix_cnt then resets to 0.
  - tuser with pix_cnt ≠ 0 sets line_err; the tuser beat counts as pixel 0.
  - tuser and tlast on the same beat: both checks apply.
- **frame_cnt** increments on every accepted tuser=1 beat, in either state.
- **err_clear:** clears line_err. If a new error occurs in the same cycle, the error wins.

## Timing
- **Reset values:**
  - m_axis_tvalid/tuser/tlast = 0, m_axis_tdata = 0
  - s_axis_tready = 1
  - line_err = 0, frame_cnt = 0, pix_cnt = 0
  - active map = 0
  - FSM = WAIT_SOF
- **Mid-operation reset:** clears all state immediately. In-flight beats are lost.
- **Latency:** an accepted beat appears on m_axis one cycle later. Throughput is 1 beat/cycle while m_axis_tready=1.
- **Output register + 1-entry skid:**
  - s_axis_tready = ~skid_valid (registered, with no combinational path from m_axis_tready).
  - If a beat is accepted while the output is held (tvalid && !tready), it goes to the skid and s_axis_tready drops the next cycle.
  - When the output drains, the skid moves to the output the same cycle and s_axis_tready rises the next cycle.
- **Held beats:** m_axis_tdata/tuser/tlast stay stable while tvalid && !tready. No beat is lost, duplicated or reordered.
- **line_err, frame_cnt:** update one cycle after the accepting edge.

## Structure
- A shared package/include holds:
  - the FSM state encodings (ST_WAIT_SOF, ST_ACTIVE)
  - the lane-select zero-code convention
  - the frame_cnt width constant (16)
- Sub-module axis_skid_buf: parametrised payload width (LANES*LANE_WIDTH+2), containing the output register and skid.
- The packer mux, FSM and line checker live in the top.

## Test plan
- **Reset:** assert reset mid-stream → next sample shows m_axis_tvalid=0, s_axis_tready=1, frame_cnt=0, line_err=0.
- **Pre-SOF drop:** 3 beats with tuser=0, then a tuser=1 beat with lane_sel={3,2,1,0} → only the 4th beat is output, 1 cycle after acceptance; frame_cnt=1.
- **Packing:** channels {0x155,0x001,0x200,0x3FF} (ch3..ch0), identity map → lanes ch0..ch3 = 0xFF,0x80,0x00,0x55; with lane 2 select = 4 → lane 2 = 0x00.
- **Frame-sync config:** change lane_sel mid-frame → the remaining beats keep the old map; the next tuser beat and all later beats use the new map.
- **Backpressure:** 640-beat line with m_axis_tready low for 5 cycles → s_axis_tready low one cycle after the stall captures the skid; output sequence equals input sequence, no gaps or duplicates.
- **Line check:** IMG_WIDTH=640, tlast on beat 639 (pix_cnt 638) → line_err=1 one cycle later. err_clear asserted alone → line_err=0. err_clear asserted together with a new error → line_err stays 1.

Source files
------------

// File: rtl/axis_lane_packer_pkg.sv
// Shared definitions for the AXIS lane packer: FSM encoding, select conventions
// and debug counter width.
package axis_lane_packer_pkg;

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_ACTIVE   = 1'b1
    } lane_state_t;

    localparam int unsigned FRAME_CNT_W = 16;

    // Any select code at or above the channel count drives an all-zero lane.
    function automatic logic is_zero_code(input int unsigned code, input int unsigned num_ch);
        return code >= num_ch;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Output register plus one-entry skid buffer; ready toward the source is a pure
// register so there is no combinational path from the downstream ready.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 34
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_acc;

    assign s_ready = ~skid_valid;
    assign in_acc  = s_valid && !skid_valid;
    assign m_valid = out_valid;
    assign m_data  = out_data;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || m_ready) begin
            // Skid has priority on drain; source is held off while it is full.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_acc;
                if (in_acc) begin
                    out_data <= s_data;
                end
            end
        end else if (in_acc) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_lane_packer.sv
// Packs runtime-selected pixel channels into output lanes; lane map, line-length
// checker and frame counter resynchronise on start-of-frame (tuser) beats.
module axis_lane_packer
    import axis_lane_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned SEL_W      = $clog2(NUM_CH + 1)
) (
    input  logic                          pixel_clk,
    input  logic                          reset,
    input  logic [LANES*SEL_W-1:0]        lane_sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tuser,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [LANES*LANE_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic                          err_clear,
    output logic                          line_err,
    output logic [FRAME_CNT_W-1:0]        frame_cnt
);

    localparam int unsigned OUT_W = LANES * LANE_WIDTH;
    localparam int unsigned PAY_W = OUT_W + 2;
    localparam int unsigned PIX_W = $clog2(IMG_WIDTH + 1);

    lane_state_t              state_q, state_d;
    logic [LANES*SEL_W-1:0]   map_q, map_eff;
    logic [PIX_W-1:0]         pix_cnt, pix_idx;
    logic                     s_ready, accept, sof, fwd;
    logic                     sof_err, eol_err, new_err;
    logic [SEL_W-1:0]         lane_code;
    logic [OUT_W-1:0]         packed_data;
    logic [PAY_W-1:0]         m_payload;
    logic [LANE_WIDTH-1:0]    ch_lane [NUM_CH];

    assign s_axis_tready = s_ready;
    assign accept        = s_axis_tvalid && s_ready;
    assign sof           = accept && s_axis_tuser;
    // An SOF beat already travels with the map it loads.
    assign map_eff       = s_axis_tuser ? lane_sel : map_q;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WAIT_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                if (sof) begin
                    state_d = ST_ACTIVE;
                    fwd     = 1'b1;
                end
            end
            ST_ACTIVE: fwd = accept;
            default:   state_d = ST_WAIT_SOF;
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        if (LANE_WIDTH <= DATA_WIDTH) begin : g_msb
            assign ch_lane[c] = s_axis_tdata[c*DATA_WIDTH + DATA_WIDTH - LANE_WIDTH +: LANE_WIDTH];
        end else begin : g_pad
            assign ch_lane[c] = {s_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH], {(LANE_WIDTH-DATA_WIDTH){1'b0}}};
        end
    end

    // Channel LSBs below the lane width are intentionally dropped.
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;

    always_comb begin
        packed_data = '0;
        lane_code   = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_code = map_eff[i*SEL_W +: SEL_W];
            if (!is_zero_code(32'(lane_code), NUM_CH)) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (lane_code == SEL_W'(c)) begin
                        packed_data[i*LANE_WIDTH +: LANE_WIDTH] = ch_lane[c];
                    end
                end
            end
        end
    end

    assign pix_idx = s_axis_tuser ? '0 : pix_cnt;
    assign sof_err = s_axis_tuser && (pix_cnt != '0);
    assign eol_err = s_axis_tlast && (pix_idx != PIX_W'(IMG_WIDTH - 1));
    assign new_err = fwd && (sof_err || eol_err);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            map_q     <= '0;
            pix_cnt   <= '0;
            line_err  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (sof) begin
                map_q     <= lane_sel;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (fwd) begin
                pix_cnt <= s_axis_tlast ? '0 : pix_idx + PIX_W'(1);
            end
            if (new_err) begin
                line_err <= 1'b1;
            end else if (err_clear) begin
                line_err <= 1'b0;
            end
        end
    end

    axis_skid_buf #(
        .WIDTH (PAY_W)
    ) u_skid (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .s_valid   (fwd),
        .s_ready   (s_ready),
        .s_data    ({s_axis_tuser, s_axis_tlast, packed_data}),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready),
        .m_data    (m_payload)
    );

    assign m_axis_tuser = m_payload[PAY_W-1];
    assign m_axis_tlast = m_payload[PAY_W-2];
    assign m_axis_tdata = m_payload[OUT_W-1:0];

endmodule

// File: tb/tb_axis_lane_packer.sv
// Directed bench for axis_lane_packer: SOF gating, lane packing, frame-synced map,
// backpressure through the skid, line checking and reset.
module tb_axis_lane_packer;

    localparam int unsigned IW = 640;
    localparam logic [39:0] DP = {10'h155, 10'h001, 10'h200, 10'h3FF};

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] lane_sel;
    logic [39:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
    logic        err_clear, line_err;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    logic [33:0] cap [$];

    axis_lane_packer #(
        .DATA_WIDTH (10),
        .NUM_CH     (4),
        .LANES      (4),
        .LANE_WIDTH (8),
        .IMG_WIDTH  (IW)
    ) dut (
        .pixel_clk     (pixel_clk),
        .reset         (reset),
        .lane_sel      (lane_sel),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_clear     (err_clear),
        .line_err      (line_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Record every completed output transfer, sampled mid-cycle.
    always @(negedge pixel_clk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            cap.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk_sel(input int unsigned s3, input int unsigned s2,
                                           input int unsigned s1, input int unsigned s0);
        logic [2:0] a3, a2, a1, a0;
        a3 = s3[2:0]; a2 = s2[2:0]; a1 = s1[2:0]; a0 = s0[2:0];
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [39:0] mk_data(input int unsigned j);
        logic [9:0] jj, c0;
        jj = j[9:0];
        c0 = {jj[7:0], 2'b11};
        return {10'h2AA, ~c0, {6'b0, jj[9:8], 2'b00}, c0};
    endfunction

    function automatic logic [33:0] exp_bp(input int unsigned j);
        logic [9:0] jj;
        jj = j[9:0];
        return {j == 0, j == IW - 1, 8'hAA, ~jj[7:0], 6'b0, jj[9:8], jj[7:0]};
    endfunction

    function automatic logic [33:0] cur_out();
        return {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    endfunction

    // Present one beat and return #1 after the edge that accepts it.
    task automatic drive(input logic [39:0] d, input logic u, input logic l);
        logic ok;
        int unsigned n;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge pixel_clk);
            ok = s_axis_tready;
            @(posedge pixel_clk);
            #1;
            n++;
        end
        chk("drive_accept", ok, 1);
    endtask

    initial begin
        int nmis;
        lane_sel = '0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b1; err_clear = 1'b0;

        repeat (3) @(posedge pixel_clk);
        #1;
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tready", s_axis_tready, 1);
        chk("reset_fcnt", frame_cnt, 0);
        chk("reset_err", line_err, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        reset = 1'b0;
        @(posedge pixel_clk); #1;

        // Pre-SOF beats are dropped; SOF beat forwarded one cycle later.
        lane_sel = mk_sel(3, 2, 1, 0);
        for (int k = 0; k < 3; k++) begin
            drive(mk_data(k), 1'b0, 1'b0);
            chk("drop_tvalid", m_axis_tvalid, 0);
        end
        drive(DP, 1'b1, 1'b0);
        chk("sof_tvalid", m_axis_tvalid, 1);
        chk("sof_out", cur_out(), {2'b10, 32'h550080FF});
        chk("sof_fcnt", frame_cnt, 1);
        s_axis_tvalid = 1'b0;
        @(posedge pixel_clk); #1;
        chk("sof_single", cap.size(), 1);
        chk("sof_no_dup", m_axis_tvalid, 0);

        // Mid-frame map change is ignored until the next SOF.
        lane_sel = mk_sel(0, 1, 2, 3);
        drive(DP, 1'b0, 1'b0);
        chk("midframe_old_map", cur_out(), {2'b00, 32'h550080FF});
        chk("no_err_yet", line_err, 0);
        drive(DP, 1'b1, 1'b0);
        chk("sof_new_map", cur_out(), {2'b10, 32'hFF800055});
        chk("sof_pix_err", line_err, 1);
        chk("fcnt_2", frame_cnt, 2);
        lane_sel = mk_sel(0, 4, 2, 3);
        drive(DP, 1'b0, 1'b0);
        chk("keep_map", cur_out(), {2'b00, 32'hFF800055});
        drive(DP, 1'b1, 1'b0);
        chk("zero_lane2", cur_out(), {2'b10, 32'hFF000055});
        chk("fcnt_3", frame_cnt, 3);
        lane_sel = mk_sel(7, 5, 4, 6);
        drive(DP, 1'b1, 1'b1);
        chk("all_zero_sel", cur_out(), {2'b11, 32'h0});
        chk("fcnt_4", frame_cnt, 4);

        s_axis_tvalid = 1'b0; err_clear = 1'b1;
        @(posedge pixel_clk); #1;
        err_clear = 1'b0;
        chk("clear_alone", line_err, 0);

        // Full-length line with a 5-cycle downstream stall.
        lane_sel = mk_sel(3, 2, 1, 0);
        cap.delete();
        for (int unsigned j = 0; j < IW; j++) begin
            if (j == 100) m_axis_tready = 1'b0;
            drive(mk_data(j), j == 0, j == IW - 1);
            if (j == 100) begin
                chk("bp_tready_low", s_axis_tready, 0);
                chk("bp_hold", cur_out(), exp_bp(99));
                for (int k = 0; k < 4; k++) begin
                    @(posedge pixel_clk); #1;
                    chk("bp_hold_stable", cur_out(), exp_bp(99));
                    chk("bp_tready_held", s_axis_tready, 0);
                end
                m_axis_tready = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("bp_count", cap.size(), IW);
        nmis = 0;
        for (int j = 0; j < cap.size(); j++) begin
            if (cap[j] !== exp_bp(j)) nmis++;
        end
        chk("bp_sequence", nmis, 0);
        chk("bp_line_ok", line_err, 0);
        chk("fcnt_5", frame_cnt, 5);

        // Short line: tlast on pix_cnt 638.
        for (int unsigned j = 0; j < IW - 1; j++) begin
            drive(mk_data(j), j == 0, j == IW - 2);
            if (j == IW - 3) chk("short_line_pre", line_err, 0);
        end
        s_axis_tvalid = 1'b0;
        chk("short_line_err", line_err, 1);
        chk("fcnt_6", frame_cnt, 6);

        err_clear = 1'b1;
        @(posedge pixel_clk); #1;
        err_clear = 1'b0;
        chk("clear_again", line_err, 0);

        err_clear = 1'b1;
        drive(mk_data(5), 1'b0, 1'b1);
        err_clear = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("err_beats_clear", line_err, 1);

        // Asynchronous reset while a beat is on the output.
        drive(mk_data(7), 1'b0, 1'b0);
        chk("pre_reset_tvalid", m_axis_tvalid, 1);
        #3 reset = 1'b1;
        #1;
        chk("mid_reset_tvalid", m_axis_tvalid, 0);
        chk("mid_reset_tready", s_axis_tready, 1);
        chk("mid_reset_fcnt", frame_cnt, 0);
        chk("mid_reset_err", line_err, 0);
        @(posedge pixel_clk); #1;
        reset = 1'b0;
        drive(mk_data(8), 1'b0, 1'b0);
        chk("post_reset_drop", m_axis_tvalid, 0);
        s_axis_tvalid = 1'b0;
        @(posedge pixel_clk); #1;
        chk("post_reset_idle", m_axis_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
